instr_fetch_unit: RTL and testbench

Fetch stage of the multi-cycle MIPS core: holds the PC, issues word requests to instruction memory, latches the returned instruction into an instruction register and presents the decoded fields to the decode/execute stage over a valid/ready handshake. It directly feeds the immediate sign-extension logic: it supplies the 16-bit immediate and the extension-enable flag (signed vs. zero extension) derived from the opcode. It also accepts PC redirects from branch/jump resolution.

---
 rtl/mips_defs.sv | 40 ++++
 rtl/instr_fetch_unit_if.sv | 43 ++++
 rtl/instr_field_decode.sv | 23 ++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding, reset PC and immediate-extension rule.
// IF_ALIGN_CHECK_EN adds the ERR fetch state for misaligned redirects.
package mips_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
`ifdef IF_ALIGN_CHECK_EN
        , ST_ERR = 2'd3
`endif
    } fetch_state_e;

    // Arithmetic, compare, branch and memory offsets are signed; logical immediates are not.
    function automatic logic imm_sign_ext(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE, OP_LW, OP_SW:              return 1'b1;
            OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return 1'b0;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decoded-instruction handshake.
// master = fetch unit, slave = memory / branch unit / decode stage.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm16;
    logic        id_ext_en;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid,
        input  id_ready,
        output id_pc, id_pc4, id_instr, id_opcode, id_funct,
        output id_rs, id_rt, id_rd, id_shamt, id_imm16, id_ext_en
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid,
        output id_ready,
        input  id_pc, id_pc4, id_instr, id_opcode, id_funct,
        input  id_rs, id_rt, id_rd, id_shamt, id_imm16, id_ext_en
    );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational instruction-word field slicer plus immediate extension select.
module instr_field_decode
    import mips_defs::*;
(
    input  logic [31:0] i_instr,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm16,
    output logic        o_ext_en
);
    assign o_opcode = i_instr[31:26];
    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    assign o_rd     = i_instr[15:11];
    assign o_shamt  = i_instr[10:6];
    assign o_funct  = i_instr[5:0];
    assign o_imm16  = i_instr[15:0];
    assign o_ext_en = imm_sign_ext(i_instr[31:26]);
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, one-outstanding-request memory FSM, instruction register and decode handshake.
// IF_ALIGN_CHECK_EN: misaligned redirects park the unit in ERR and raise if_misalign.
module instr_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    bus
`ifdef IF_ALIGN_CHECK_EN
    , output logic                if_misalign
`endif
);
    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_ir, r_id_pc;
    logic         r_kill, w_kill_nxt;
    logic         w_ld_ir, w_req;
    logic [31:0]  w_redir_pc;

    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};

`ifdef IF_ALIGN_CHECK_EN
    logic r_mis, w_mis_nxt;
    logic w_redir_bad;
    assign w_redir_bad = |bus.redirect_pc[1:0];
    assign if_misalign = r_mis;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^bus.redirect_pc[1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_ld_ir     = 1'b0;
        w_req       = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        w_mis_nxt   = r_mis;
`endif
        case (r_state)
            // A redirect in REQ suppresses the request so no orphan response is ever outstanding.
            ST_REQ: begin
                w_req       = !bus.redirect_valid;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (r_kill || bus.redirect_valid) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_ld_ir     = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.id_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = r_state;
        endcase

        // Redirect overrides everything, including a same-cycle accept.
        if (bus.redirect_valid) begin
            w_pc_nxt = w_redir_pc;
            if (r_state == ST_WAIT && !bus.imem_rvalid) begin
                w_kill_nxt  = 1'b1;
                w_state_nxt = ST_WAIT;
            end else begin
                w_kill_nxt  = 1'b0;
                w_state_nxt = ST_REQ;
            end
`ifdef IF_ALIGN_CHECK_EN
            w_mis_nxt = w_redir_bad;
`endif
        end

`ifdef IF_ALIGN_CHECK_EN
        if (w_mis_nxt && w_state_nxt == ST_REQ)
            w_state_nxt = ST_ERR;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_ir    <= '0;
            r_id_pc <= '0;
`ifdef IF_ALIGN_CHECK_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
`ifdef IF_ALIGN_CHECK_EN
            r_mis   <= w_mis_nxt;
`endif
            if (w_ld_ir) begin
                r_ir    <= bus.imem_rdata;
                r_id_pc <= r_pc;
            end
        end
    end

    assign bus.imem_req  = w_req && rst_n;
    assign bus.imem_addr = r_pc;
    assign bus.id_valid  = (r_state == ST_HOLD) && rst_n;
    assign bus.id_pc     = r_id_pc;
    assign bus.id_pc4    = r_id_pc + 32'd4;
    assign bus.id_instr  = r_ir;

    instr_field_decode u_dec (
        .i_instr  (r_ir),
        .o_opcode (bus.id_opcode),
        .o_rs     (bus.id_rs),
        .o_rt     (bus.id_rt),
        .o_rd     (bus.id_rd),
        .o_shamt  (bus.id_shamt),
        .o_funct  (bus.id_funct),
        .o_imm16  (bus.id_imm16),
        .o_ext_en (bus.id_ext_en)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of the fetch protocol.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

`ifdef IF_ALIGN_CHECK_EN
    logic if_misalign;
    instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .if_misalign(if_misalign));
`else
    instr_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    function automatic logic ref_ext(input logic [31:0] w);
        return w[31:26] inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rv, input logic [31:0] rpc, input logic rdy,
                          input logic vld, input logic [31:0] dat);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        bus.imem_rvalid    = vld;
        bus.imem_rdata     = dat;
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.id_valid); end
        checks++; if (bus.id_instr !== 32'h0) begin errors++; $display("FAIL rst_ir: got %h want 0", bus.id_instr); end
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL rst_idpc: got %h want 0", bus.id_pc); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h3000) begin errors++; $display("FAIL first_addr: got %h want 3000", bus.imem_addr); end
    endtask

    task automatic test_first_fetch();
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h2008FFFF);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL c2_valid: got %b want 0", bus.id_valid); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL c3_valid: got %b want 1", bus.id_valid); end
        checks++; if (bus.id_imm16 !== 16'hFFFF) begin errors++; $display("FAIL addi_imm: got %h want ffff", bus.id_imm16); end
        checks++; if (bus.id_ext_en !== 1'b1) begin errors++; $display("FAIL addi_ext: got %b want 1", bus.id_ext_en); end
        checks++; if (bus.id_rt !== 5'd8) begin errors++; $display("FAIL addi_rt: got %0d want 8", bus.id_rt); end
        checks++; if (bus.id_opcode !== 6'h08) begin errors++; $display("FAIL addi_op: got %h want 08", bus.id_opcode); end
        checks++; if (bus.id_pc4 !== 32'h3004) begin errors++; $display("FAIL addi_pc4: got %h want 3004", bus.id_pc4); end
        tick();
        bus.id_ready = 1'b1;
        @(negedge clk);
        tick();
        bus.id_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
            errors++; $display("FAIL next_req: got req=%b addr=%h want req=1 addr=3004", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h3508FFFF);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h3508FFFF || bus.id_ext_en !== 1'b0 ||
                          bus.imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b ir=%h ext=%b req=%b want v=1 ir=3508ffff ext=0 req=0",
                                   i, bus.id_valid, bus.id_instr, bus.id_ext_en, bus.imem_req); end
            tick();
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        tick();
        bus.id_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin
            errors++; $display("FAIL stall_next: got req=%b addr=%h want req=1 addr=3004", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        tick();
        set_in(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
            errors++; $display("FAIL kill_wait: got v=%b req=%b want 0 0", bus.id_valid, bus.imem_req); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b want 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4000) begin
            errors++; $display("FAIL redir_req: got req=%b addr=%h want req=1 addr=4000", bus.imem_req, bus.imem_addr); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h8C020004);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h8C020004 || bus.id_pc !== 32'h4000 ||
                      bus.id_ext_en !== 1'b1) begin
            errors++; $display("FAIL lw_hold: got v=%b ir=%h pc=%h ext=%b want 1 8c020004 4000 1",
                               bus.id_valid, bus.id_instr, bus.id_pc, bus.id_ext_en); end
    endtask

    task automatic test_redirect_vs_ready();
        tick();
        set_in(1'b1, 32'h5000, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rvr_valid: got %b want 0", bus.id_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h5000) begin
            errors++; $display("FAIL rvr_req: got req=%b addr=%h want req=1 addr=5000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        tick();
        set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h3C01FFFF);
        tick();
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc4 !== 32'h0 || bus.id_ext_en !== 1'b0) begin
            errors++; $display("FAIL wrap_hold: got v=%b pc4=%h ext=%b want 1 0 0", bus.id_valid, bus.id_pc4, bus.id_ext_en); end
        tick();
        bus.id_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
    endtask

`ifdef IF_ALIGN_CHECK_EN
    task automatic test_misalign();
        do_reset();
        set_in(1'b1, 32'h4002, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (if_misalign !== 1'b1 || bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0) begin
            errors++; $display("FAIL mis_err: got mis=%b req=%b v=%b want 1 0 0", if_misalign, bus.imem_req, bus.id_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mis_noreq%0d: got %b want 0", i, bus.imem_req); end
        end
        tick();
        set_in(1'b1, 32'h4004, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (if_misalign !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4004) begin
            errors++; $display("FAIL mis_clear: got mis=%b req=%b addr=%h want 0 1 4004", if_misalign, bus.imem_req, bus.imem_addr); end
    endtask
`else
    task automatic test_force_align();
        do_reset();
        set_in(1'b1, 32'h4002, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL align_gate: got %b want 0", bus.imem_req); end
        tick();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4000) begin
            errors++; $display("FAIL align_req: got req=%b addr=%h want req=1 addr=4000", bus.imem_req, bus.imem_addr); end
    endtask
`endif

    // Model: at most one outstanding fetch; a held word waits for accept; a redirect
    // discards the held word and marks an outstanding fetch as stale.
    task automatic test_random();
        logic [31:0] m_pc = 32'h3000, m_addr = 32'h0, m_word = 32'h0, m_id_pc = 32'h0, mem_word = 32'h0;
        logic        m_out = 1'b0, m_stale = 1'b0, m_held = 1'b0;
        int          cnt = 0;
        logic        r, y, v, exp_req;
        logic [31:0] tgt, d;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v = 1'b0;
            d = $urandom;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin v = 1'b1; d = mem_word; end
            end else if (!m_out && $urandom_range(0, 7) == 0) begin
                v = 1'b1;
            end
            r   = ($urandom_range(0, 15) == 0);
            tgt = $urandom;
`ifdef IF_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
            y = $urandom_range(0, 1) == 1;
            set_in(r, tgt, y, v, d);
            @(negedge clk);
            exp_req = !m_out && !m_held && !r;
            checks++; if (bus.imem_req !== exp_req) begin
                errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (bus.imem_addr !== m_pc) begin
                    errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.imem_addr, m_pc); end
            end
            checks++; if (bus.id_valid !== m_held) begin
                errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.id_valid, m_held); end
            if (m_held) begin
                checks++; if (bus.id_pc !== m_id_pc || bus.id_pc4 !== m_id_pc + 32'd4 || bus.id_instr !== m_word) begin
                    errors++; $display("FAIL rnd_id c%0d: got pc=%h pc4=%h ir=%h want %h %h %h", c,
                                       bus.id_pc, bus.id_pc4, bus.id_instr, m_id_pc, m_id_pc + 32'd4, m_word); end
                checks++; if ({bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct} !== m_word ||
                              bus.id_imm16 !== m_word[15:0] || bus.id_ext_en !== ref_ext(m_word)) begin
                    errors++; $display("FAIL rnd_fields c%0d: got op=%h rs=%h rt=%h rd=%h sh=%h fn=%h imm=%h ext=%b for word %h",
                                       c, bus.id_opcode, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct,
                                       bus.id_imm16, bus.id_ext_en, m_word); end
            end
            if (r) begin
                m_pc   = {tgt[31:2], 2'b00};
                m_held = 1'b0;
                if (m_out) begin
                    if (v) begin m_out = 1'b0; m_stale = 1'b0; end
                    else m_stale = 1'b1;
                end
            end else if (exp_req) begin
                m_out    = 1'b1;
                m_addr   = m_pc;
                cnt      = $urandom_range(1, 3);
                mem_word = $urandom;
            end else if (m_out && v) begin
                m_out = 1'b0;
                if (m_stale) m_stale = 1'b0;
                else begin m_held = 1'b1; m_id_pc = m_addr; m_word = d; end
            end else if (m_held && y) begin
                m_held = 1'b0;
                m_pc   = m_pc + 32'd4;
            end
            tick();
        end
    endtask

    initial begin
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_vs_ready();
        test_wrap();
`ifdef IF_ALIGN_CHECK_EN
        test_misalign();
`else
        test_force_align();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
